sr_cmd_gen: RTL and testbench



---
 rtl/sr_cmd_gen.sv | 164 ++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen
//   Drive side of a synchronous SR trigger. Converts a requested level (d)
//   into mutually exclusive, width-controlled set/reset pulses for a
//   downstream SR trigger clocked by the same clk. It keeps a copy of the
//   commanded level (exp) and only issues a pulse when d differs from it.
//   It can optionally watch the trigger's q (q_fb) and raise a sticky error
//   if the trigger does not follow within FB_TIMEOUT cycles.
//
// Parameters
//   PULSE_W    : width of each s/r pulse in clk cycles (>= 1)
//   GAP_W      : idle cycles forced after each command (0 = no gap)
//   FB_CHECK   : 1 = check q_fb after each pulse, 0 = ignore q_fb
//   FB_TIMEOUT : cycles to wait for q_fb == exp before flagging err (>= 1)
//
// Ports
//   clk     in  : clock
//   nrst    in  : asynchronous active-low reset
//   en      in  : permits new commands; a command in progress always completes
//   d       in  : requested trigger level
//   s       out : set pulse (registered)
//   r       out : reset pulse (registered)
//   q_fb    in  : downstream trigger q, synchronous to clk
//   exp     out : last commanded level
//   busy    out : high while a command (pulse / feedback wait / gap) runs
//   err     out : sticky feedback-timeout flag
//   err_clr in  : clears err (a simultaneous timeout wins)

module sr_cmd_gen #(
    parameter int PULSE_W    = 1,
    parameter int GAP_W      = 0,
    parameter int FB_CHECK   = 1,
    parameter int FB_TIMEOUT = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic d,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic exp,
    output logic busy,
    output logic err,
    input  logic err_clr
);

    // One shared counter serves every timed state, so it is sized for the
    // longest of the three intervals and never has to wrap.
    localparam int MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAX_W  = (MAX_PG > FB_TIMEOUT) ? MAX_PG : FB_TIMEOUT;
    localparam int CW     = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W);
    localparam logic [CW-1:0] PULSE_PRE  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W);
    localparam logic [CW-1:0] FB_LAST    = CW'(FB_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        WAIT_FB = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Successor states are fixed by the parameters, so resolve them once.
    localparam state_t AFTER_FB    = (GAP_W > 0) ? GAP : IDLE;
    localparam state_t AFTER_PULSE = (FB_CHECK != 0) ? WAIT_FB : AFTER_FB;

    state_t        state;
    logic          target;
    logic [CW-1:0] cnt;

    // The counter holds the 1-based index of the current cycle inside a timed
    // state; it is loaded with 1 on entry and compared against the last index.
    // NOTE: every register here is updated with <= so that all branches see
    // the pre-edge values of state, cnt and exp within the same clock edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            target <= 1'b0;
            cnt    <= '0;
            s      <= 1'b0;
            r      <= 1'b0;
            exp    <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            // NOTE: the clear is written before the timeout set below, so when
            // both happen on one edge the later assignment (set) takes effect.
            if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en && (d != exp)) begin
                        state  <= PULSE;
                        target <= d;
                        s      <= d;
                        r      <= ~d;
                        busy   <= 1'b1;
                        cnt    <= CNT_ONE;
                        // A one-cycle pulse is its own last cycle, so exp
                        // must move together with the rising pulse.
                        if (PULSE_W == 1) begin
                            exp <= d;
                        end
                    end
                end

                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        s     <= 1'b0;
                        r     <= 1'b0;
                        state <= AFTER_PULSE;
                        busy  <= (AFTER_PULSE != IDLE);
                        cnt   <= (AFTER_PULSE != IDLE) ? CNT_ONE : '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        // Entering the last pulse cycle: exp becomes visible
                        // during that cycle and stays as the pulse falls.
                        if (cnt == PULSE_PRE) begin
                            exp <= target;
                        end
                    end
                end

                WAIT_FB: begin
                    if ((q_fb == exp) || (cnt == FB_LAST)) begin
                        // No retry on timeout: exp keeps the commanded level.
                        if (q_fb != exp) begin
                            err <= 1'b1;
                        end
                        state <= AFTER_FB;
                        busy  <= (AFTER_FB != IDLE);
                        cnt   <= (AFTER_FB != IDLE) ? CNT_ONE : '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen
//   Directed bench for sr_cmd_gen. Four instances share clk/nrst and cover
//   the different parameter sets:
//     u_t2 : PULSE_W=3, GAP_W=0, FB_CHECK=0   (idle, set/reset, en gating)
//     u_t3 : PULSE_W=1, GAP_W=0, FB_CHECK=1, FB_TIMEOUT=4 (feedback, err)
//     u_t4 : PULSE_W=1, GAP_W=5, FB_CHECK=0   (request glitches while busy)
//     u_t6 : PULSE_W=8, GAP_W=0, FB_CHECK=0   (async reset mid-pulse)
//   Inputs change on the falling edge and outputs are checked on the falling
//   edge, so every value seen is the one registered at the previous rising
//   edge. Each observed vector is {s, r, exp, busy, err}.

module tb_sr_cmd_gen;

    logic clk;
    logic nrst;

    logic t2_en, t2_d, t2_s, t2_r, t2_exp, t2_busy, t2_err, t2_clr;
    logic t3_en, t3_d, t3_s, t3_r, t3_exp, t3_busy, t3_err, t3_clr, t3_qfb;
    logic t4_en, t4_d, t4_s, t4_r, t4_exp, t4_busy, t4_err, t4_clr;
    logic t6_en, t6_d, t6_s, t6_r, t6_exp, t6_busy, t6_err, t6_clr;

    logic t3_force;
    logic t3_fval;
    logic model_q;

    int checks = 0;
    int errors = 0;

    logic [4:0] v2, v3, v4, v6;
    assign v2 = {t2_s, t2_r, t2_exp, t2_busy, t2_err};
    assign v3 = {t3_s, t3_r, t3_exp, t3_busy, t3_err};
    assign v4 = {t4_s, t4_r, t4_exp, t4_busy, t4_err};
    assign v6 = {t6_s, t6_r, t6_exp, t6_busy, t6_err};

    sr_cmd_gen #(.PULSE_W(3), .GAP_W(0), .FB_CHECK(0), .FB_TIMEOUT(16)) u_t2 (
        .clk(clk), .nrst(nrst), .en(t2_en), .d(t2_d), .s(t2_s), .r(t2_r),
        .q_fb(1'b0), .exp(t2_exp), .busy(t2_busy), .err(t2_err), .err_clr(t2_clr)
    );

    sr_cmd_gen #(.PULSE_W(1), .GAP_W(0), .FB_CHECK(1), .FB_TIMEOUT(4)) u_t3 (
        .clk(clk), .nrst(nrst), .en(t3_en), .d(t3_d), .s(t3_s), .r(t3_r),
        .q_fb(t3_qfb), .exp(t3_exp), .busy(t3_busy), .err(t3_err), .err_clr(t3_clr)
    );

    sr_cmd_gen #(.PULSE_W(1), .GAP_W(5), .FB_CHECK(0), .FB_TIMEOUT(16)) u_t4 (
        .clk(clk), .nrst(nrst), .en(t4_en), .d(t4_d), .s(t4_s), .r(t4_r),
        .q_fb(1'b0), .exp(t4_exp), .busy(t4_busy), .err(t4_err), .err_clr(t4_clr)
    );

    sr_cmd_gen #(.PULSE_W(8), .GAP_W(0), .FB_CHECK(0), .FB_TIMEOUT(16)) u_t6 (
        .clk(clk), .nrst(nrst), .en(t6_en), .d(t6_d), .s(t6_s), .r(t6_r),
        .q_fb(1'b0), .exp(t6_exp), .busy(t6_busy), .err(t6_err), .err_clr(t6_clr)
    );

    // Model SR trigger closing the feedback loop for u_t3.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            model_q <= 1'b0;
        end else if (t3_s) begin
            model_q <= 1'b1;
        end else if (t3_r) begin
            model_q <= 1'b0;
        end
    end

    assign t3_qfb = t3_force ? t3_fval : model_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed {s,r,exp,busy,err}=%b expected %b", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        nrst = 1'b0;
        t2_en = 1'b0; t2_d = 1'b0; t2_clr = 1'b0;
        t3_en = 1'b0; t3_d = 1'b0; t3_clr = 1'b0;
        t4_en = 1'b0; t4_d = 1'b0; t4_clr = 1'b0;
        t6_en = 1'b0; t6_d = 1'b0; t6_clr = 1'b0;
        t3_force = 1'b0; t3_fval = 1'b0;

        // ---- reset and idle ----
        tick(); check("reset_t2", v2, 5'b00000);
        check("reset_t6", v6, 5'b00000);
        nrst = 1'b1;
        t2_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); check("idle_d0", v2, 5'b00000);
        end

        // ---- set then reset, PULSE_W=3 ----
        t2_d = 1'b1;
        tick(); check("set_c1", v2, 5'b10010);
        tick(); check("set_c2", v2, 5'b10010);
        tick(); check("set_c3_exp", v2, 5'b10110);
        tick(); check("set_done", v2, 5'b00100);
        t2_d = 1'b0;
        tick(); check("rst_c1", v2, 5'b01110);
        tick(); check("rst_c2", v2, 5'b01110);
        tick(); check("rst_c3_exp", v2, 5'b01010);
        tick(); check("rst_done", v2, 5'b00000);

        // ---- en gating ----
        t2_en = 1'b0;
        t2_d  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("en0_no_pulse", v2, 5'b00000);
        end
        t2_en = 1'b1;
        tick(); check("en_rise_pulse", v2, 5'b10010);
        t2_en = 1'b0;
        tick(); check("en_drop_c2", v2, 5'b10010);
        tick(); check("en_drop_c3", v2, 5'b10110);
        tick(); check("en_drop_done", v2, 5'b00100);
        t2_d = 1'b0;
        tick(); check("en0_hold_a", v2, 5'b00100);
        tick(); check("en0_hold_b", v2, 5'b00100);

        // ---- feedback from model trigger ----
        t3_en = 1'b1;
        t3_d  = 1'b1;
        tick(); check("fb_set_pulse", v3, 5'b10110);
        tick(); check("fb_set_wait", v3, 5'b00110);
        tick(); check("fb_set_done", v3, 5'b00100);
        t3_d = 1'b0;
        tick(); check("fb_rst_pulse", v3, 5'b01010);
        tick(); check("fb_rst_wait", v3, 5'b00010);
        tick(); check("fb_rst_done", v3, 5'b00000);

        // ---- feedback timeout, q_fb stuck at 0 ----
        t3_force = 1'b1;
        t3_fval  = 1'b0;
        t3_d     = 1'b1;
        tick(); check("to_pulse", v3, 5'b10110);
        for (int i = 0; i < 4; i++) begin
            tick(); check("to_wait", v3, 5'b00110);
        end
        tick(); check("to_err_set", v3, 5'b00101);
        tick(); check("to_err_sticky", v3, 5'b00101);
        t3_clr = 1'b1;
        tick(); check("to_err_clr", v3, 5'b00100);
        t3_clr = 1'b0;

        // ---- timeout and err_clr on the same edge: set wins ----
        t3_fval = 1'b1;
        t3_d    = 1'b0;
        tick(); check("tc_pulse", v3, 5'b01010);
        for (int i = 0; i < 3; i++) begin
            tick(); check("tc_wait", v3, 5'b00010);
        end
        tick(); check("tc_wait_last", v3, 5'b00010);
        t3_clr = 1'b1;
        tick(); check("tc_set_dominates", v3, 5'b00001);
        t3_clr = 1'b0;
        tick(); check("tc_err_holds", v3, 5'b00001);
        t3_clr = 1'b1;
        tick(); check("tc_err_cleared", v3, 5'b00000);
        t3_clr = 1'b0;

        // ---- glitches on d while busy, final d matches exp ----
        t4_en = 1'b1;
        t4_d  = 1'b1;
        tick(); check("gl_a_pulse", v4, 5'b10110);
        t4_d = 1'b0;
        tick(); check("gl_a_gap1", v4, 5'b00110);
        t4_d = 1'b1;
        tick(); check("gl_a_gap2", v4, 5'b00110);
        t4_d = 1'b0;
        tick(); check("gl_a_gap3", v4, 5'b00110);
        t4_d = 1'b1;
        tick(); check("gl_a_gap4", v4, 5'b00110);
        tick(); check("gl_a_gap5", v4, 5'b00110);
        tick(); check("gl_a_idle", v4, 5'b00100);
        tick(); check("gl_a_no_r", v4, 5'b00100);

        // bring exp back to 0
        t4_d = 1'b0;
        tick(); check("gl_back_r", v4, 5'b01010);
        for (int i = 0; i < 5; i++) begin
            tick(); check("gl_back_gap", v4, 5'b00010);
        end
        tick(); check("gl_back_idle", v4, 5'b00000);

        // ---- glitches on d while busy, final d differs from exp ----
        t4_d = 1'b1;
        tick(); check("gl_b_pulse", v4, 5'b10110);
        t4_d = 1'b0;
        tick(); check("gl_b_gap1", v4, 5'b00110);
        t4_d = 1'b1;
        tick(); check("gl_b_gap2", v4, 5'b00110);
        t4_d = 1'b0;
        tick(); check("gl_b_gap3", v4, 5'b00110);
        tick(); check("gl_b_gap4", v4, 5'b00110);
        tick(); check("gl_b_gap5", v4, 5'b00110);
        tick(); check("gl_b_idle", v4, 5'b00100);
        tick(); check("gl_b_r_pulse", v4, 5'b01010);
        tick(); check("gl_b_r_gap", v4, 5'b00010);

        // ---- async reset in the 4th cycle of an 8-cycle pulse ----
        t6_en = 1'b1;
        t6_d  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(); check("ar_pulse_pre", v6, 5'b10010);
        end
        nrst = 1'b0;
        #1;
        check("ar_async_clear", v6, 5'b00000);
        tick(); check("ar_held", v6, 5'b00000);
        nrst = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(); check("ar_new_pulse", v6, 5'b10010);
        end
        tick(); check("ar_new_last", v6, 5'b10110);
        tick(); check("ar_new_done", v6, 5'b00100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
